// File: rtl/alu_pkg.sv
// Shared definitions for the ALU frame sequencer: FSM states, ALU select codes
// and the bit layout of the op byte.
package alu_pkg;

  typedef enum logic [2:0] {
    StGetA,
    StGetB,
    StGetOp,
    StExec,
    StResult
  } state_e;

  localparam logic [2:0] SEL_ADD = 3'd0;
  localparam logic [2:0] SEL_SUB = 3'd1;
  localparam logic [2:0] SEL_AND = 3'd2;
  localparam logic [2:0] SEL_OR  = 3'd3;
  localparam logic [2:0] SEL_XOR = 3'd4;
  localparam logic [2:0] SEL_NOT = 3'd5;
  localparam logic [2:0] SEL_SHL = 3'd6;
  localparam logic [2:0] SEL_SHR = 3'd7;

  localparam int unsigned OP_SEL_LSB   = 0;
  localparam int unsigned OP_SEL_W     = 3;
  localparam int unsigned OP_CHAIN_BIT = 7;

endpackage

// File: rtl/alu_frame_sequencer_if.sv
// Byte-in, ALU and result handshake signals of the frame sequencer.
// The master side is the sequencer; the slave side is producer, ALU and consumer.
interface alu_frame_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_result;
  logic       alu_cout;
  logic [7:0] res_data;
  logic       res_cout;
  logic       res_valid;
  logic       res_ready;
  logic       busy;

  modport master (
    input  in_data, in_valid, alu_result, alu_cout, res_ready,
    output in_ready, alu_a, alu_b, alu_sel, res_data, res_cout, res_valid, busy
  );

  modport slave (
    output in_data, in_valid, alu_result, alu_cout, res_ready,
    input  in_ready, alu_a, alu_b, alu_sel, res_data, res_cout, res_valid, busy
  );
endinterface

// File: rtl/alu_frame_sequencer.sv
// Assembles A, B, op byte frames into registered ALU operands, waits ALU_LATENCY
// cycles and offers the captured Result/Cout on a valid/ready handshake.
module alu_frame_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LATENCY = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  alu_frame_sequencer_if.master bus
);

  localparam int unsigned     CntW    = $clog2(ALU_LATENCY + 2);
  localparam logic [CntW-1:0] CntLast = CntW'(ALU_LATENCY);

  state_e          state_q, state_d;
  logic [7:0]      alu_a_q, alu_a_d;
  logic [7:0]      alu_b_q, alu_b_d;
  logic [2:0]      alu_sel_q, alu_sel_d;
  logic [7:0]      res_data_q, res_data_d;
  logic            res_cout_q, res_cout_d;
  logic            chain_q, chain_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // in_ready is high in every GET state, so in_valid alone marks a transfer there.
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    res_data_d = res_data_q;
    res_cout_d = res_cout_q;
    chain_d    = chain_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StGetA: begin
        if (bus.in_valid) begin
          alu_a_d = bus.in_data;
          state_d = StGetB;
        end
      end
      StGetB: begin
        if (bus.in_valid) begin
          alu_b_d = bus.in_data;
          state_d = StGetOp;
        end
      end
      StGetOp: begin
        if (bus.in_valid) begin
          alu_sel_d = bus.in_data[OP_SEL_LSB +: OP_SEL_W];
          chain_d   = bus.in_data[OP_CHAIN_BIT];
          cnt_d     = '0;
          state_d   = StExec;
        end
      end
      StExec: begin
        if (cnt_q == CntLast) begin
          res_data_d = bus.alu_result;
          res_cout_d = bus.alu_cout;
          state_d    = StResult;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResult: begin
        if (bus.res_ready) begin
          // A chained frame reuses the result as A and only needs B and op.
          if (chain_q) begin
            alu_a_d = res_data_q;
            state_d = StGetB;
          end else begin
            state_d = StGetA;
          end
        end
      end
      default: state_d = StGetA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StGetA;
      alu_a_q    <= 8'h00;
      alu_b_q    <= 8'h00;
      alu_sel_q  <= 3'b000;
      res_data_q <= 8'h00;
      res_cout_q <= 1'b0;
      chain_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      res_data_q <= res_data_d;
      res_cout_q <= res_cout_d;
      chain_q    <= chain_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == StGetA) || (state_q == StGetB) || (state_q == StGetOp);
  assign bus.res_valid = (state_q == StResult);
  assign bus.busy      = (state_q != StGetA);
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_cout  = res_cout_q;

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Bench for alu_frame_sequencer: one instance on a combinational stub ALU and
// one with ALU_LATENCY=3 on a 3-stage delayed stub, checked against scoreboards.
module tb_alu_frame_sequencer;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  logic [8:0] sb0[$];
  logic [8:0] sb3[$];

  alu_frame_sequencer_if if0 ();
  alu_frame_sequencer_if if3 ();

  alu_frame_sequencer #(.ALU_LATENCY(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  alu_frame_sequencer #(.ALU_LATENCY(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] s);
    case (s)
      SEL_ADD: return {1'b0, a} + {1'b0, b};
      SEL_SUB: return {1'b0, a} - {1'b0, b};
      SEL_AND: return {1'b0, a & b};
      SEL_OR:  return {1'b0, a | b};
      SEL_XOR: return {1'b0, a ^ b};
      SEL_NOT: return {1'b0, ~a};
      SEL_SHL: return {a, 1'b0};
      default: return {a[0], 1'b0, a[7:1]};
    endcase
  endfunction

  assign {if0.alu_cout, if0.alu_result} = alu_ref(if0.alu_a, if0.alu_b, if0.alu_sel);

  logic [8:0] p1 = '0;
  logic [8:0] p2 = '0;
  logic [8:0] p3 = '0;
  always @(posedge clk) begin
    p1 <= alu_ref(if3.alu_a, if3.alu_b, if3.alu_sel);
    p2 <= p1;
    p3 <= p2;
  end
  assign {if3.alu_cout, if3.alu_result} = p3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers: called and return at 1ns after a rising edge.
  task automatic put0(input logic [7:0] b);
    int n = 0;
    if0.in_data  = b;
    if0.in_valid = 1'b1;
    while (!if0.in_ready && n < 100) begin @(posedge clk); #1; n++; end
    total_cnt++;
    if (!if0.in_ready) $display("FAIL put0_timeout: in_ready=%0b required 1", if0.in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
  endtask

  task automatic put3(input logic [7:0] b);
    int n = 0;
    if3.in_data  = b;
    if3.in_valid = 1'b1;
    while (!if3.in_ready && n < 100) begin @(posedge clk); #1; n++; end
    total_cnt++;
    if (!if3.in_ready) $display("FAIL put3_timeout: in_ready=%0b required 1", if3.in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    if3.in_valid = 1'b0;
  endtask

  task automatic take0(output logic [8:0] got);
    int n = 0;
    if0.res_ready = 1'b1;
    while (!if0.res_valid && n < 100) begin @(posedge clk); #1; n++; end
    total_cnt++;
    if (!if0.res_valid) $display("FAIL take0_timeout: res_valid=0 required 1");
    else pass_cnt++;
    got = {if0.res_cout, if0.res_data};
    @(posedge clk); #1;
    if0.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if0.in_valid = 1'b0; if0.res_ready = 1'b0; if0.in_data = 8'h00;
    if3.in_valid = 1'b0; if3.res_ready = 1'b0; if3.in_data = 8'h00;
    #2;
    total_cnt++;
    if (if0.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", if0.in_ready);
    else pass_cnt++;
    total_cnt++;
    if (if0.res_valid !== 1'b0) $display("FAIL reset_res_valid: got %0b want 0", if0.res_valid);
    else pass_cnt++;
    total_cnt++;
    if (if0.busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", if0.busy);
    else pass_cnt++;
    total_cnt++;
    if ({if0.alu_a, if0.alu_b, if0.alu_sel} !== 19'h0)
      $display("FAIL reset_alu: got a=%0h b=%0h sel=%0h want 0", if0.alu_a, if0.alu_b,
               if0.alu_sel);
    else pass_cnt++;
    total_cnt++;
    if ({if0.res_cout, if0.res_data} !== 9'h0)
      $display("FAIL reset_res: got %0h want 0", {if0.res_cout, if0.res_data});
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [8:0] got, exp;
    put0(8'h12); put0(8'h34); put0(8'h00);
    sb0.push_back(alu_ref(8'h12, 8'h34, SEL_ADD));
    total_cnt++;
    if ({if0.alu_a, if0.alu_b, if0.alu_sel} !== {8'h12, 8'h34, 3'd0})
      $display("FAIL add_operands: got a=%0h b=%0h sel=%0h want 12 34 0", if0.alu_a,
               if0.alu_b, if0.alu_sel);
    else pass_cnt++;
    total_cnt++;
    if (if0.res_valid !== 1'b0 || if0.busy !== 1'b1)
      $display("FAIL add_exec: got res_valid=%0b busy=%0b want 0 1", if0.res_valid, if0.busy);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (if0.res_valid !== 1'b1) $display("FAIL add_latency: res_valid=%0b want 1", if0.res_valid);
    else pass_cnt++;
    take0(got);
    exp = sb0.pop_front();
    total_cnt++;
    if (got !== exp) $display("FAIL add_result: got %0h want %0h", got, exp);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    logic [8:0] snap, exp;
    int n = 0;
    int bad = 0;
    put0(8'hF0); put0(8'h20); put0(8'h00);
    sb0.push_back(alu_ref(8'hF0, 8'h20, SEL_ADD));
    while (!if0.res_valid && n < 20) begin @(posedge clk); #1; n++; end
    snap = {if0.res_cout, if0.res_data};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!if0.res_valid || if0.in_ready || {if0.res_cout, if0.res_data} !== snap) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL stall_hold: %0d unstable cycles want 0", bad);
    else pass_cnt++;
    if0.res_ready = 1'b1;
    @(posedge clk); #1;
    if0.res_ready = 1'b0;
    total_cnt++;
    if (if0.in_ready !== 1'b1 || if0.res_valid !== 1'b0)
      $display("FAIL stall_release: in_ready=%0b res_valid=%0b want 1 0", if0.in_ready,
               if0.res_valid);
    else pass_cnt++;
    exp = sb0.pop_front();
    total_cnt++;
    if (snap !== exp) $display("FAIL stall_result: got %0h want %0h", snap, exp);
    else pass_cnt++;
  endtask

  task automatic test_chain();
    logic [8:0] got, exp;
    put0(8'h05); put0(8'h03); put0(8'h80);
    sb0.push_back(alu_ref(8'h05, 8'h03, SEL_ADD));
    take0(got);
    exp = sb0.pop_front();
    total_cnt++;
    if (got !== exp) $display("FAIL chain_first: got %0h want %0h", got, exp);
    else pass_cnt++;
    put0(8'h02); put0(8'h00);
    sb0.push_back(alu_ref(8'h08, 8'h02, SEL_ADD));
    total_cnt++;
    if (if0.alu_a !== 8'h08 || if0.alu_b !== 8'h02)
      $display("FAIL chain_operands: got a=%0h b=%0h want 8 2", if0.alu_a, if0.alu_b);
    else pass_cnt++;
    take0(got);
    exp = sb0.pop_front();
    total_cnt++;
    if (got !== exp) $display("FAIL chain_second: got %0h want %0h", got, exp);
    else pass_cnt++;
    put0(8'h01); put0(8'h02); put0(8'h01);
    sb0.push_back(alu_ref(8'h01, 8'h02, SEL_SUB));
    total_cnt++;
    if (if0.alu_a !== 8'h01 || if0.alu_b !== 8'h02 || if0.alu_sel !== SEL_SUB)
      $display("FAIL chain_after: got a=%0h b=%0h sel=%0h want 1 2 1", if0.alu_a, if0.alu_b,
               if0.alu_sel);
    else pass_cnt++;
    take0(got);
    exp = sb0.pop_front();
    total_cnt++;
    if (got !== exp) $display("FAIL chain_third: got %0h want %0h", got, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_exec();
    logic [8:0] got, exp;
    put0(8'h11); put0(8'h22); put0(8'h84);
    total_cnt++;
    if (if0.busy !== 1'b1 || if0.alu_sel !== SEL_XOR)
      $display("FAIL rst_exec_entry: busy=%0b sel=%0h want 1 4", if0.busy, if0.alu_sel);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({if0.alu_a, if0.alu_b, if0.alu_sel, if0.res_data} !== 27'h0)
      $display("FAIL rst_async_clear: got a=%0h b=%0h sel=%0h res=%0h want 0", if0.alu_a,
               if0.alu_b, if0.alu_sel, if0.res_data);
    else pass_cnt++;
    total_cnt++;
    if (if0.busy !== 1'b0 || if0.in_ready !== 1'b1 || if0.res_valid !== 1'b0)
      $display("FAIL rst_async_ctrl: busy=%0b in_ready=%0b res_valid=%0b want 0 1 0",
               if0.busy, if0.in_ready, if0.res_valid);
    else pass_cnt++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    put0(8'h07); put0(8'h01); put0(8'h00);
    sb0.push_back(alu_ref(8'h07, 8'h01, SEL_ADD));
    total_cnt++;
    if (if0.alu_a !== 8'h07) $display("FAIL rst_next_a: got %0h want 7", if0.alu_a);
    else pass_cnt++;
    take0(got);
    exp = sb0.pop_front();
    total_cnt++;
    if (got !== exp) $display("FAIL rst_next_result: got %0h want %0h", got, exp);
    else pass_cnt++;
  endtask

  task automatic test_latency();
    logic [7:0] a, b;
    logic [2:0] sel;
    logic [8:0] got, exp;
    int n = 0;
    int bad = 0;
    put3(8'h10); put3(8'h20); put3(8'h00);
    sb3.push_back(alu_ref(8'h10, 8'h20, SEL_ADD));
    while (!if3.res_valid && n < 40) begin @(posedge clk); #1; n++; end
    got = {if3.res_cout, if3.res_data};
    if3.res_ready = 1'b1;
    @(posedge clk); #1;
    if3.res_ready = 1'b0;
    exp = sb3.pop_front();
    total_cnt++;
    if (got !== exp) $display("FAIL lat_first: got %0h want %0h", got, exp);
    else pass_cnt++;
    put3(8'h01); put3(8'h01); put3(8'h04);
    sb3.push_back(alu_ref(8'h01, 8'h01, SEL_XOR));
    a = if3.alu_a; b = if3.alu_b; sel = if3.alu_sel;
    n = 0;
    while (!if3.res_valid && n < 40) begin
      if (if3.alu_a !== a || if3.alu_b !== b || if3.alu_sel !== sel) bad++;
      n++;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (n != 4) $display("FAIL lat_exec_cycles: got %0d want 4", n);
    else pass_cnt++;
    total_cnt++;
    if (bad != 0 || {a, b, sel} !== {8'h01, 8'h01, 3'd4})
      $display("FAIL lat_hold: %0d changes a=%0h b=%0h sel=%0h want 0 1 1 4", bad, a, b, sel);
    else pass_cnt++;
    got = {if3.res_cout, if3.res_data};
    if3.res_ready = 1'b1;
    @(posedge clk); #1;
    if3.res_ready = 1'b0;
    exp = sb3.pop_front();
    total_cnt++;
    if (got !== exp) $display("FAIL lat_second: got %0h want %0h", got, exp);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b, cur;
    logic [8:0] obs, exp;
    logic       rdy, rv, rr;
    int stage = 0;
    int sent = 0;
    int got = 0;
    int dead = 0;
    int cyc = 0;
    a = 8'h00; b = 8'h00;
    cur = 8'($urandom);
    if0.in_data  = cur;
    if0.in_valid = 1'b1;
    while (got < 200 && cyc < 20000) begin
      rdy = if0.in_ready;
      rv  = if0.res_valid;
      obs = {if0.res_cout, if0.res_data};
      rr  = ($urandom_range(0, 3) != 0);
      if0.res_ready = rr;
      if (!rdy && !rv) dead++;
      @(posedge clk); #1;
      cyc++;
      if (rdy && if0.in_valid) begin
        if (stage == 0) begin
          a = cur; stage = 1;
        end else if (stage == 1) begin
          b = cur; stage = 2;
        end else begin
          exp = alu_ref(a, b, cur[2:0]);
          sb0.push_back(exp);
          sent++;
          if (cur[7]) begin a = exp[7:0]; stage = 1; end
          else stage = 0;
        end
        if (sent == 200) if0.in_valid = 1'b0;
        cur = 8'($urandom);
        if0.in_data = cur;
      end
      if (rv && rr) begin
        got++;
        total_cnt++;
        if (sb0.size() == 0) begin
          $display("FAIL stream_extra: result %0h with empty scoreboard", obs);
        end else begin
          exp = sb0.pop_front();
          if (obs !== exp) $display("FAIL stream_result %0d: got %0h want %0h", got, obs, exp);
          else pass_cnt++;
        end
      end
    end
    if0.in_valid  = 1'b0;
    if0.res_ready = 1'b0;
    total_cnt++;
    if (got != 200 || sent != 200)
      $display("FAIL stream_count: got %0d results %0d frames want 200", got, sent);
    else pass_cnt++;
    total_cnt++;
    if (sb0.size() != 0) $display("FAIL stream_leftover: %0d pending want 0", sb0.size());
    else pass_cnt++;
    total_cnt++;
    if (dead != 200) $display("FAIL stream_bubbles: got %0d want 200", dead);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_stall();
    test_chain();
    test_reset_mid_exec();
    test_latency();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
